contador_asc_desc: RTL and testbench



---
 rtl/contador_asc_desc.sv | 108 ++++++++++
 tb/tb_contador_asc_desc.sv | 126 ++++++++++++
 2 files changed

// File: rtl/contador_asc_desc.sv
// rtl/contador_asc_desc.sv - modulo-(MAX+1) up/down counter with load, terminal-count pulse and optional prescaler (CONTADOR_ASC_DESC_PRESCALER_EN)
module contador_asc_desc #(
  parameter int MAX = 7,
  parameter int DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] din,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       tc
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  // Reject parameter values the 4-bit datapath and the prescaler cannot honour.
  if (MAX < 1 || MAX > 15 || DIV < 1) begin : g_bad_param
    $error("contador_asc_desc: MAX must be 1..15 and DIV must be >= 1");
  end

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       tc_q;
  logic       tc_d;
  logic       tick;

`ifdef CONTADOR_ASC_DESC_PRESCALER_EN
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  // Prescaler: restarts on load or tick, advances only while enabled.
  always_comb begin
    tick  = en && (pre_q == PRE_LAST);
    pre_d = pre_q;
    if (load) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  // Without the prescaler every enabled edge advances the count.
  always_comb begin
    tick = en;
  end
`endif

  // Next count and wrap pulse; load beats tick, a value above MAX wraps like an end-of-range.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (load) begin
      cnt_d = (din > MAX_V) ? MAX_V : din;
    end else if (tick) begin
      if (up) begin
        if (cnt_q >= MAX_V) begin
          cnt_d = 4'd0;
          tc_d  = (cnt_q == MAX_V);
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        if (cnt_q == 4'd0) begin
          cnt_d = MAX_V;
          tc_d  = 1'b1;
        end else if (cnt_q > MAX_V) begin
          cnt_d = MAX_V;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    end
  end

  // Count and terminal-count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign {W, X, Y, Z} = cnt_q;
  assign tc           = tc_q;

endmodule

// File: tb/tb_contador_asc_desc.sv
// tb/tb_contador_asc_desc.sv - scoreboard bench for contador_asc_desc (prescaler macro undefined, MAX=7)
module tb_contador_asc_desc;

  localparam int MAX = 7;

  typedef struct {
    int cnt;
    int tc;
    int idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic       W, X, Y, Z, tc;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   drv_done = 1'b0;

  int   model_cnt = 0;
  int   model_tc = 0;

  contador_asc_desc #(.MAX(MAX), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
    .W(W), .X(X), .Y(Y), .Z(Z), .tc(tc)
  );

  always #5 clk = ~clk;

  // Drive inputs at the falling edge, then push the reference outcome of the rising edge.
  task automatic step(input bit r, input bit e, input bit u, input bit l, input int d);
    exp_t ex;
    @(negedge clk);
    rst_n = r; en = e; up = u; load = l; din = 4'(d);
    @(posedge clk);
    if (!r) begin
      model_cnt = 0;
      model_tc  = 0;
    end else if (l) begin
      model_cnt = (d > MAX) ? MAX : d;
      model_tc  = 0;
    end else if (e) begin
      if (u) begin
        model_tc  = (model_cnt == MAX) ? 1 : 0;
        model_cnt = (model_cnt + 1) % (MAX + 1);
      end else begin
        model_tc  = (model_cnt == 0) ? 1 : 0;
        model_cnt = (model_cnt + MAX) % (MAX + 1);
      end
    end else begin
      model_tc = 0;
    end
    ex.cnt = model_cnt;
    ex.tc  = model_tc;
    ex.idx = pushed;
    exp_q.push_back(ex);
    pushed++;
  endtask

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    repeat (9) step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 2);
    repeat (4) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 1, 12);
    step(1, 0, 1, 1, 5);
    repeat (4) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 1, 7);
    step(1, 1, 1, 1, 3);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 15);
    step(1, 0, 1, 1, 6);
    step(0, 1, 1, 1, 9);
    step(1, 1, 1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)));
    end
    drv_done = 1'b1;
  end

  // Monitor: after every rising edge, compare outputs against queued expectations.
  initial begin
    exp_t ex;
    int   cycles = 0;
    while (!drv_done || exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      cycles++;
      while (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        popped++;
        vectors++;
        if ({W, X, Y, Z} !== 4'(ex.cnt) || tc !== 1'(ex.tc)) begin
          miscompares++;
          $display("FAIL vec%0d: WXYZ=%b tc=%b, required WXYZ=%b tc=%0d",
                   ex.idx, {W, X, Y, Z}, tc, 4'(ex.cnt), ex.tc);
        end
      end
      if (cycles > 5000) begin
        miscompares++;
        $display("FAIL timeout: monitor ran %0d cycles, required drain within 5000", cycles);
        break;
      end
    end
    vectors++;
    if (popped != pushed || pushed == 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: popped %0d, required %0d", popped, pushed);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
